ssd_scan_driver_2digit: RTL and testbench

//  Downstream consumer of the 30-to-0 BCD countdown counter. Takes the counter's

---
 rtl/ssd_scan_driver_2digit_pkg.sv | 49 ++++
 rtl/ssd_scan_driver_2digit_bcd_to_ssd.sv | 15 +
 rtl/ssd_scan_driver_2digit.sv | 156 +++++++++++++++
 tb/tb_ssd_scan_driver_2digit.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ssd_scan_driver_2digit_pkg.sv
// Shared constants, digit-slot enum and the nibble-to-segment helper for the
// 2-digit scan driver. Segment codes are active-low, bit 7 = dp, 6:0 = g..a.
package ssd_scan_driver_2digit_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam logic [3:0] AN_DIG0   = 4'b1110;
    localparam logic [3:0] AN_DIG1   = 4'b1101;

    // Scan slots: only the two low digits carry data, the upper two stay dark.
    typedef enum logic [1:0] {
        DIG_ONES  = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_DARK2 = 2'd2,
        DIG_DARK3 = 2'd3
    } digit_e;

    // Map one BCD nibble to its active-low segment pattern; non-decimal shows a dash.
    function automatic logic [7:0] seg_lookup(input logic [3:0] nibble);
        logic [7:0] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_2digit_bcd_to_ssd.sv
// Combinational BCD nibble to active-low 7-segment decoder (dp held off).
module ssd_scan_driver_2digit_bcd_to_ssd
    import ssd_scan_driver_2digit_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    // Pure table lookup; values above 9 decode to a dash.
    always_comb begin
        o_seg = SEG_BLANK;
        o_seg = seg_lookup(i_nibble);
    end

endmodule

// File: rtl/ssd_scan_driver_2digit.sv
// Two-digit scan driver for a 4-digit common-anode 7-segment display.
// Samples the packed BCD value once per scan frame (tear-free), blanks a
// leading zero in the tens place and keeps digits 3:2 dark.
// Optional feature macro: SSD_BLINK_AT_ZERO_EN -- flashes the "0" shown
// when the sampled value is 00, with a half-period of 2**(BLINK_W-1) frames.
module ssd_scan_driver_2digit
    import ssd_scan_driver_2digit_pkg::*;
#(
    parameter int PRESCALE_W = 16,
    parameter int BLINK_W    = 6
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bcd_in,
    output logic [7:0] ssd_seg,
    output logic [3:0] ssd_an
);

    logic [PRESCALE_W-1:0] r_prescale;
    logic [1:0]            r_digit_idx;
    logic [7:0]            r_disp;
    logic [7:0]            r_ssd_seg;
    logic [3:0]            r_ssd_an;

    logic                  w_tick;
    logic                  w_frame_end;
    logic [7:0]            w_ones_seg;
    logic [7:0]            w_tens_seg;
    logic [7:0]            w_seg_scan;
    logic [3:0]            w_an_scan;
    logic [7:0]            w_seg_next;
    logic [3:0]            w_an_next;

    // Degenerate widths elaborate nothing; this keeps both widths referenced in every build.
    if (PRESCALE_W < 1 || BLINK_W < 1) begin : g_param_guard
    end

    assign w_tick      = &r_prescale;
    assign w_frame_end = w_tick && (r_digit_idx == 2'd3);

    // Free-running refresh prescaler; its all-ones state is the digit tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + PRESCALE_W'(1);
        end
    end

    // Digit index advances on every tick and wraps 3 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit_idx <= 2'd0;
        end else if (w_tick) begin
            r_digit_idx <= r_digit_idx + 2'd1;
        end
    end

    // Input is captured only at the frame boundary so a frame never mixes two values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp <= 8'h00;
        end else if (w_frame_end) begin
            r_disp <= bcd_in;
        end
    end

    ssd_scan_driver_2digit_bcd_to_ssd u_ones_dec (
        .i_nibble (r_disp[3:0]),
        .o_seg    (w_ones_seg)
    );

    ssd_scan_driver_2digit_bcd_to_ssd u_tens_dec (
        .i_nibble (r_disp[7:4]),
        .o_seg    (w_tens_seg)
    );

    // Select anode and segment pattern for the slot currently being scanned.
    always_comb begin
        w_an_scan  = AN_OFF;
        w_seg_scan = SEG_BLANK;
        case (r_digit_idx)
            DIG_ONES: begin
                w_an_scan  = AN_DIG0;
                w_seg_scan = w_ones_seg;
            end
            DIG_TENS: begin
                w_an_scan = AN_DIG1;
                if (r_disp[7:4] == 4'd0) begin
                    w_seg_scan = SEG_BLANK;
                end else begin
                    w_seg_scan = w_tens_seg;
                end
            end
            DIG_DARK2: begin
                w_an_scan  = AN_OFF;
                w_seg_scan = SEG_BLANK;
            end
            DIG_DARK3: begin
                w_an_scan  = AN_OFF;
                w_seg_scan = SEG_BLANK;
            end
            default: begin
                w_an_scan  = AN_OFF;
                w_seg_scan = SEG_BLANK;
            end
        endcase
    end

`ifdef SSD_BLINK_AT_ZERO_EN
    logic [BLINK_W-1:0] r_frame_cnt;

    // Frame counter bumps at each frame boundary; its MSB is the blink phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_frame_end) begin
            r_frame_cnt <= r_frame_cnt + BLINK_W'(1);
        end
    end

    // At expiry (value 00) the whole display goes dark during the odd blink phase.
    always_comb begin
        w_an_next  = w_an_scan;
        w_seg_next = w_seg_scan;
        if ((r_disp == 8'h00) && r_frame_cnt[BLINK_W-1]) begin
            w_an_next  = AN_OFF;
            w_seg_next = SEG_BLANK;
        end else begin
            w_an_next  = w_an_scan;
            w_seg_next = w_seg_scan;
        end
    end
`else
    // Without blinking the scanned pattern goes straight to the output registers.
    always_comb begin
        w_an_next  = w_an_scan;
        w_seg_next = w_seg_scan;
    end
`endif

    // Output registers: dark immediately on reset, otherwise one clock behind the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ssd_an  <= AN_OFF;
            r_ssd_seg <= SEG_BLANK;
        end else begin
            r_ssd_an  <= w_an_next;
            r_ssd_seg <= w_seg_next;
        end
    end

    assign ssd_an  = r_ssd_an;
    assign ssd_seg = r_ssd_seg;

endmodule

// File: tb/tb_ssd_scan_driver_2digit.sv
// Directed bench for ssd_scan_driver_2digit with PRESCALE_W=2, BLINK_W=2:
// one digit slot lasts 4 clocks, one frame 16 clocks. "cyc" counts rising
// edges since reset release; outputs seen after edge k reflect slot
// ((k-1)/4)%4 of frame (k-1)/16, whose value was sampled at edge 16*frame.
module tb_ssd_scan_driver_2digit;

    logic       clk;
    logic       rst_n;
    logic [7:0] bcd_in;
    logic [7:0] ssd_seg;
    logic [3:0] ssd_an;

    int n_cmp;
    int n_bad;
    int cyc;

    ssd_scan_driver_2digit #(
        .PRESCALE_W (2),
        .BLINK_W    (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bcd_in  (bcd_in),
        .ssd_seg (ssd_seg),
        .ssd_an  (ssd_an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic run_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
        end
    endtask

    task automatic chk_slot(input string tag, input int k, input logic [3:0] an, input logic [7:0] seg);
        run_to(k);
        chk({tag, "_an"}, {4'h0, ssd_an}, {4'h0, an});
        chk({tag, "_seg"}, ssd_seg, seg);
    endtask

    logic [3:0] blk_an;
    logic [7:0] blk_seg;

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        bcd_in = 8'h00;
`ifdef SSD_BLINK_AT_ZERO_EN
        blk_an  = 4'b1111;
        blk_seg = 8'hFF;
`else
        blk_an  = 4'b1110;
        blk_seg = 8'hC0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", {4'h0, ssd_an}, 8'h0F);
        chk("rst_seg", ssd_seg, 8'hFF);

        @(negedge clk);
        rst_n  = 1'b1;
        bcd_in = 8'h30;
        cyc    = 0;

        // Frame 0 still shows the reset value 00.
        chk_slot("f0_ones", 1, 4'b1110, 8'hC0);
        chk_slot("f0_tens", 5, 4'b1101, 8'hFF);
        chk_slot("f0_d2",   9, 4'b1111, 8'hFF);

        // Frame 1: 30.
        chk_slot("v30_ones", 17, 4'b1110, 8'hC0);
        chk_slot("v30_tens", 21, 4'b1101, 8'hB0);
        chk_slot("v30_d2",   25, 4'b1111, 8'hFF);
        chk_slot("v30_d3",   29, 4'b1111, 8'hFF);
        bcd_in = 8'h07;

        // Frame 2: 07, tens blanked.
        chk_slot("v07_ones", 33, 4'b1110, 8'hF8);
        chk_slot("v07_tens", 37, 4'b1101, 8'hFF);
        run_to(40);
        bcd_in = 8'h25;

        // Frame 3: 25, input changes to 24 mid-frame but display holds.
        chk_slot("v25_ones", 49, 4'b1110, 8'h92);
        bcd_in = 8'h24;
        chk_slot("v25_hold", 52, 4'b1110, 8'h92);
        chk_slot("v25_tens", 53, 4'b1101, 8'hA4);
        chk_slot("v25_d3",   64, 4'b1111, 8'hFF);

        // Frame 4: 24.
        chk_slot("v24_ones", 65, 4'b1110, 8'h99);
        chk_slot("v24_tens", 69, 4'b1101, 8'hA4);
        bcd_in = 8'h3A;

        // Frame 5: 3A -> dash on ones.
        chk_slot("v3A_ones", 81, 4'b1110, 8'hBF);
        chk_slot("v3A_tens", 85, 4'b1101, 8'hB0);
        bcd_in = 8'h00;

        // Frames 6..10: 00, frame_cnt 2,3 dark (if blinking), 0,1 lit, 2 dark.
        chk_slot("z_f6",  97, blk_an, blk_seg);
        chk_slot("z_f7", 113, blk_an, blk_seg);
        chk_slot("z_f8", 129, 4'b1110, 8'hC0);
        chk_slot("z_f8_tens", 133, 4'b1101, 8'hFF);
        chk_slot("z_f9", 145, 4'b1110, 8'hC0);

        // Reset mid-frame: outputs go dark before any clock edge.
        run_to(146);
        bcd_in = 8'h12;
        rst_n  = 1'b0;
        #1;
        chk("mid_rst_an", {4'h0, ssd_an}, 8'h0F);
        chk("mid_rst_seg", ssd_seg, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        chk_slot("post_rst_ones", 1, 4'b1110, 8'hC0);
        chk_slot("post_rst_tens", 5, 4'b1101, 8'hFF);
        chk_slot("post_rst_v12",  17, 4'b1110, 8'hA4);
        chk_slot("post_rst_v12t", 21, 4'b1101, 8'hF9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
